ps2_key_event_controller: RTL



---
 rtl/ps2_key_event_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_controller.sv
// ps2_key_event_controller: turns PS/2 scan bytes into make/break key events,
// filters typematic repeats and queues events in a fall-through FIFO.
`default_nettype none

module ps2_key_event_controller #(
  parameter int W             = 2,
  parameter int TO_CYCLES     = 300000,
  parameter int TO_W          = 19,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_done_tick,
  input  logic [7:0]   rx_byte,
  output logic         rx_en,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [7:0]   evt_code,
  output logic         evt_ext,
  output logic         evt_break,
  output logic [W:0]   evt_count,
  output logic         overflow
);

  localparam int DEPTH = 2 ** W;
  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t          state;
  logic [TO_W-1:0] timer;
  logic [8:0]      held;
  logic            held_valid;

  logic [9:0]      mem [DEPTH];
  logic [W-1:0]    wr_ptr;
  logic [W-1:0]    rd_ptr;
  logic [W:0]      count;

  logic            is_status;
  logic            accepted;
  logic            emit;
  logic            emit_ext;
  logic            emit_brk;
  logic            suppress;
  logic            push_req;
  logic            full;
  logic            pop;
  logic            push;

  // Controller/self-test status bytes are never key data.
  always_comb begin
    case (rx_byte)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                   is_status = 1'b0;
    endcase
  end

  assign accepted = rx_done_tick && !is_status;

  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (accepted && rx_byte != PREFIX_EXT && rx_byte != PREFIX_BRK) begin
      emit     = 1'b1;
      emit_ext = (state == EXT) || (state == EXT_BRK);
      emit_brk = (state == BRK) || (state == EXT_BRK);
    end
  end

  assign suppress = FILTER_REPEAT && !emit_brk && held_valid &&
                    (held == {emit_ext, rx_byte});
  assign push_req = emit && !suppress;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else if (accepted) begin
      timer <= '0;
      if (rx_byte == PREFIX_EXT) begin
        state <= EXT;
      end else if (rx_byte == PREFIX_BRK) begin
        state <= (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state <= IDLE;
      end
    end else if (!rx_done_tick && state != IDLE) begin
      // An abandoned prefix falls back to IDLE without producing an event.
      if (timer == TO_W'(TO_CYCLES - 1)) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held       <= '0;
      held_valid <= 1'b0;
    end else if (emit) begin
      if (!emit_brk && !suppress) begin
        held       <= {emit_ext, rx_byte};
        held_valid <= 1'b1;
      end else if (emit_brk && held_valid && held == {emit_ext, rx_byte}) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign full = (count == (W+1)'(DEPTH));
  assign pop  = (count != '0) && evt_ready;
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {emit_ext, emit_brk, rx_byte};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  assign evt_valid = (count != '0);
  assign evt_ext   = mem[rd_ptr][9];
  assign evt_break = mem[rd_ptr][8];
  assign evt_code  = mem[rd_ptr][7:0];
  assign evt_count = count;
  // Throttle one entry early so a byte already in flight still fits.
  assign rx_en     = (count < (W+1)'(DEPTH - 1));

endmodule

`default_nettype wire
